// File: rtl/string_ram_buffer.sv
// rtl/string_ram_buffer.sv - character line buffer with append, backspace and sequenced clear
module string_ram_buffer #(
    parameter int               DEPTH = 80,
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] FILL  = 8'h20,
    parameter int               AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             we,
    input  logic             back,
    input  logic             clear_flag,
    input  logic [AW-1:0]    str_out,
    output logic [WIDTH-1:0] out,
    output logic             overload,
    output logic             state,
    output logic             nextstate,
    output logic             str_clear_flag,
    output logic [AW-1:0]    clear_count
);

    localparam int                WPW     = $clog2(DEPTH + 1);
    localparam logic [0:0]        S_WRITE = 1'b0;
    localparam logic [0:0]        S_CLEAR = 1'b1;
    localparam logic [WPW-1:0]    WP_FULL = WPW'(DEPTH);
    localparam logic [AW-1:0]     CC_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WPW-1:0]   wp_q, wp_d;
    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    clear_count_q, clear_count_d;
    logic             clr_prev_q, clr_prev_d;
    logic             overload_q, overload_d;
    logic             str_clear_flag_q, str_clear_flag_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             clear_req;

    assign clear_req = clear_flag & ~clr_prev_q;

    always_comb begin
        mem_d            = mem_q;
        wp_d             = wp_q;
        state_d          = state_q;
        clear_count_d    = clear_count_q;
        clr_prev_d       = clear_flag;
        str_clear_flag_d = 1'b0;
        out_d            = '0;

        if (32'(str_out) < DEPTH) begin
            out_d = mem_q[str_out];
        end

        if (state_q == S_WRITE) begin
            // A fresh clear request swallows this cycle's append/backspace.
            if (clear_req) begin
                state_d       = S_CLEAR;
                clear_count_d = '0;
            end else if (back) begin
                if (wp_q != '0) begin
                    mem_d[AW'(wp_q - 1'b1)] = FILL;
                    wp_d                    = wp_q - 1'b1;
                end
            end else if (we && (wp_q < WP_FULL)) begin
                mem_d[AW'(wp_q)] = in;
                wp_d             = wp_q + 1'b1;
            end
        end else begin
            mem_d[clear_count_q] = FILL;
            if (clear_count_q == CC_LAST) begin
                state_d          = S_WRITE;
                wp_d             = '0;
                clear_count_d    = '0;
                str_clear_flag_d = 1'b1;
            end else begin
                clear_count_d = clear_count_q + 1'b1;
            end
        end

        overload_d = (wp_d == WP_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q            <= '{default: FILL};
            wp_q             <= '0;
            state_q          <= S_WRITE;
            clear_count_q    <= '0;
            clr_prev_q       <= clear_flag;
            overload_q       <= 1'b0;
            str_clear_flag_q <= 1'b0;
            out_q            <= '0;
        end else begin
            mem_q            <= mem_d;
            wp_q             <= wp_d;
            state_q          <= state_d;
            clear_count_q    <= clear_count_d;
            clr_prev_q       <= clr_prev_d;
            overload_q       <= overload_d;
            str_clear_flag_q <= str_clear_flag_d;
            out_q            <= out_d;
        end
    end

    assign out            = out_q;
    assign overload       = overload_q;
    assign state          = state_q;
    assign nextstate      = state_d;
    assign str_clear_flag = str_clear_flag_q;
    assign clear_count    = clear_count_q;

endmodule

// File: tb/tb_string_ram_buffer.sv
// tb/tb_string_ram_buffer.sv - directed self-checking bench for string_ram_buffer
module tb_string_ram_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in = '0;
    logic       we = 1'b0;
    logic       back = 1'b0;
    logic       clear_flag = 1'b0;
    logic [6:0] str_out = '0;
    logic [7:0] out;
    logic       overload;
    logic       state;
    logic       nextstate;
    logic       str_clear_flag;
    logic [6:0] clear_count;

    int checks = 0;
    int failures = 0;

    string_ram_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .in             (in),
        .we             (we),
        .back           (back),
        .clear_flag     (clear_flag),
        .str_out        (str_out),
        .out            (out),
        .overload       (overload),
        .state          (state),
        .nextstate      (nextstate),
        .str_clear_flag (str_clear_flag),
        .clear_count    (clear_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge; out is valid one edge after str_out is set.
    task automatic rd(input int addr, input logic [7:0] exp, input string tag);
        str_out = 7'(addr);
        @(negedge clk);
        check(tag, {24'h0, out}, {24'h0, exp});
    endtask

    task automatic wr(input logic [7:0] c);
        we = 1'b1;
        in = c;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n_clear;
        int pulses;
        int cc_err;
        bit found;

        @(negedge clk);
        do_reset();
        check("rst_state", {31'h0, state}, 32'd0);
        check("rst_overload", {31'h0, overload}, 32'd0);
        check("rst_clear_count", {25'h0, clear_count}, 32'd0);
        check("rst_clr_pulse", {31'h0, str_clear_flag}, 32'd0);
        check("rst_out", {24'h0, out}, 32'd0);
        rd(5, 8'h20, "rst_cell5");

        // Append and backspace.
        wr("A"); wr("B"); wr("C");
        back = 1'b1;
        @(negedge clk);
        back = 1'b0;
        rd(0, "A", "abc_0");
        rd(1, "B", "abc_1");
        rd(2, 8'h20, "abc_bs_2");
        wr("D");
        rd(2, "D", "abc_next_2");
        rd(3, 8'h20, "abc_3");
        back = 1'b1; we = 1'b1; in = "E";
        @(negedge clk);
        back = 1'b0; we = 1'b0;
        rd(2, 8'h20, "back_prio_2");
        rd(3, 8'h20, "back_prio_3");

        // Backspace on an empty buffer does nothing, next write lands at 0.
        do_reset();
        back = 1'b1;
        @(negedge clk);
        back = 1'b0;
        wr("x");
        rd(0, "x", "bs_empty_0");
        rd(1, 8'h20, "bs_empty_1");

        // Fill to full with 101.
        do_reset();
        we = 1'b1; in = 8'd101;
        repeat (79) @(negedge clk);
        check("ovl_at_79", {31'h0, overload}, 32'd0);
        @(negedge clk);
        check("ovl_at_80", {31'h0, overload}, 32'd1);
        in = 8'd7;
        repeat (3) @(negedge clk);
        we = 1'b0;
        check("ovl_held", {31'h0, overload}, 32'd1);
        for (int a = 0; a < 80; a++) rd(a, 8'd101, $sformatf("full_%0d", a));

        // Clear with clear_flag held high.
        clear_flag = 1'b1;
        #1;
        check("clr_nextstate", {31'h0, nextstate}, 32'd1);
        check("clr_state_pre", {31'h0, state}, 32'd0);
        n_clear = 0; pulses = 0; cc_err = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (state) begin
                if (clear_count != 7'(n_clear)) cc_err++;
                n_clear++;
            end
            if (str_clear_flag) pulses++;
        end
        check("clr_cycles", n_clear, 32'd80);
        check("clr_count_seq_errs", cc_err, 32'd0);
        check("clr_pulses", pulses, 32'd1);
        check("clr_overload", {31'h0, overload}, 32'd0);
        check("clr_state_post", {31'h0, state}, 32'd0);
        rd(0, 8'h20, "clr_cell0");
        rd(40, 8'h20, "clr_cell40");
        rd(79, 8'h20, "clr_cell79");
        wr("Q");
        rd(0, "Q", "resume_0");
        rd(1, 8'h20, "resume_1");
        check("no_reclear", {31'h0, state}, 32'd0);
        clear_flag = 1'b0;
        @(negedge clk);

        // Reset in the middle of a clear.
        clear_flag = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (state && clear_count == 7'd40) found = 1'b1;
        end
        check("mid_clear_reached", {31'h0, found}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", {31'h0, state}, 32'd0);
        check("midrst_cc", {25'h0, clear_count}, 32'd0);
        @(negedge clk);
        check("midrst_no_trigger", {31'h0, state}, 32'd0);
        rd(0, 8'h20, "midrst_0");
        rd(41, 8'h20, "midrst_41");
        rd(79, 8'h20, "midrst_79");

        // Out-of-range read address.
        rd(100, 8'h00, "oor_100");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
